// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage.
// Contents: pc_src encodings, FSM state constants, IF/ID word layout,
// bubble instruction default and the PC increment helper.
package fetch_pkg;

    // pc_src encodings driven by the decode-stage branch resolver
    localparam logic [2:0] PCSRC_SEQ = 3'b001;
    localparam logic [2:0] PCSRC_BR  = 3'b011;
    localparam logic [2:0] PCSRC_JMP = 3'b100;
    localparam logic [2:0] PCSRC_JR  = 3'b010;

    // Fetch FSM states
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Default bubble instruction
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

    // One fetched instruction together with the PC+2 that follows it
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
    } fetch_word_t;

    // Sequential successor; wraps naturally at 16 bits
    function automatic logic [15:0] pc_plus2(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection for the fetch stage.
// Ports:
//   pc_i            current fetch PC
//   pc_src_i/flush_i redirect control from decode
//   br/jmp/jr_target_i candidate redirect targets
//   next_pc_o       aligned redirect target, or pc+2 when not redirecting
//   redirect_o      a legal redirect is requested this cycle
//   err_pulse_o     illegal control encoding or misaligned target this cycle
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [15:0] pc_i,
    input  logic [2:0]  pc_src_i,
    input  logic        flush_i,
    input  logic [15:0] br_target_i,
    input  logic [15:0] jmp_target_i,
    input  logic [15:0] jr_target_i,
    output logic [15:0] next_pc_o,
    output logic        redirect_o,
    output logic        err_pulse_o
);

    logic [15:0] target_s;
    logic        redirect_s;
    logic        legal_s;

    // Decode pc_src/flush: only a recognised redirect code with flush set redirects;
    // anything inconsistent is flagged and falls back to sequential fetch
    always_comb begin
        target_s   = jr_target_i;
        redirect_s = 1'b0;
        legal_s    = 1'b1;
        case (pc_src_i)
            PCSRC_SEQ: begin
                legal_s = ~flush_i;
            end
            PCSRC_BR: begin
                target_s   = br_target_i;
                redirect_s = flush_i;
                legal_s    = flush_i;
            end
            PCSRC_JMP: begin
                target_s   = jmp_target_i;
                redirect_s = flush_i;
                legal_s    = flush_i;
            end
            PCSRC_JR: begin
                target_s   = jr_target_i;
                redirect_s = flush_i;
                legal_s    = flush_i;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    assign next_pc_o   = redirect_s ? {target_s[15:1], 1'b0} : pc_plus2(pc_i);
    assign redirect_o  = redirect_s;
    assign err_pulse_o = ~legal_s | (redirect_s & target_s[0]);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer and IF/ID register owner.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc_src, flush, *_target  redirect request from decode
//   stall, halt_dec     hazard stall of IF/ID, HALT seen in IF/ID
//   imem_rd/imem_addr   request to the stalling instruction memory (held until imem_done)
//   imem_data/imem_done returned instruction and completion strobe
//   if_id_*             IF/ID register contents presented to decode
//   err                 sticky illegal-control / misaligned-target flag
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pc_src,
    input  logic        flush,
    input  logic [15:0] br_target,
    input  logic [15:0] jmp_target,
    input  logic [15:0] jr_target,
    input  logic        stall,
    input  logic        halt_dec,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc_inc,
    output logic        if_id_valid,
    output logic        err
);

    localparam fetch_word_t BUBBLE = '{instr: NOP_INSTR, pc_inc: 16'h0000};

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] redir_q, redir_d;
    fetch_word_t hold_q, hold_d;
    fetch_word_t ifid_q, ifid_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        halt_pend_q, halt_pend_d;
    logic        err_q, err_d;

    logic [15:0] next_pc_s;
    logic        redirect_s;
    logic        err_pulse_s;

    next_pc_sel u_next_pc_sel (
        .pc_i        (pc_q),
        .pc_src_i    (pc_src),
        .flush_i     (flush),
        .br_target_i (br_target),
        .jmp_target_i(jmp_target),
        .jr_target_i (jr_target),
        .next_pc_o   (next_pc_s),
        .redirect_o  (redirect_s),
        .err_pulse_o (err_pulse_s)
    );

    // Next-state logic: priority is redirect > halt > stall > normal fetch
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_d      = redir_q;
        hold_d       = hold_q;
        ifid_d       = ifid_q;
        ifid_valid_d = ifid_valid_q;
        halt_pend_d  = halt_pend_q;
        err_d        = err_q | err_pulse_s;
        case (state_q)
            ST_FETCH: begin
                if (redirect_s) begin
                    ifid_d       = BUBBLE;
                    ifid_valid_d = 1'b0;
                    halt_pend_d  = 1'b0;
                    if (imem_done) begin
                        pc_d = next_pc_s;
                    end else begin
                        // Request must complete at the old address first
                        redir_d = next_pc_s;
                        state_d = ST_DRAIN;
                    end
                end else if (halt_dec || halt_pend_q) begin
                    // halt_dec vanishes once IF/ID is bubbled, so remember it
                    ifid_d       = BUBBLE;
                    ifid_valid_d = 1'b0;
                    if (imem_done) begin
                        state_d     = ST_HALT;
                        halt_pend_d = 1'b0;
                    end else begin
                        halt_pend_d = 1'b1;
                    end
                end else if (imem_done) begin
                    pc_d = next_pc_s;
                    if (stall) begin
                        hold_d  = '{instr: imem_data, pc_inc: next_pc_s};
                        state_d = ST_HOLD;
                    end else begin
                        ifid_d       = '{instr: imem_data, pc_inc: next_pc_s};
                        ifid_valid_d = 1'b1;
                    end
                end else if (!stall) begin
                    // Decode consumed IF/ID but nothing new arrived
                    ifid_d       = BUBBLE;
                    ifid_valid_d = 1'b0;
                end else begin
                    ifid_d = ifid_q;
                end
            end
            ST_DRAIN: begin
                if (redirect_s) begin
                    redir_d = next_pc_s;
                end else begin
                    redir_d = redir_q;
                end
                if (imem_done) begin
                    pc_d    = redirect_s ? next_pc_s : redir_q;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (redirect_s) begin
                    hold_d       = BUBBLE;
                    pc_d         = next_pc_s;
                    ifid_d       = BUBBLE;
                    ifid_valid_d = 1'b0;
                    state_d      = ST_FETCH;
                end else if (halt_dec) begin
                    hold_d       = BUBBLE;
                    ifid_d       = BUBBLE;
                    ifid_valid_d = 1'b0;
                    state_d      = ST_HALT;
                end else if (!stall) begin
                    ifid_d       = hold_q;
                    ifid_valid_d = 1'b1;
                    state_d      = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            redir_q      <= 16'h0000;
            hold_q       <= BUBBLE;
            ifid_q       <= BUBBLE;
            ifid_valid_q <= 1'b0;
            halt_pend_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_q      <= redir_d;
            hold_q       <= hold_d;
            ifid_q       <= ifid_d;
            ifid_valid_q <= ifid_valid_d;
            halt_pend_q  <= halt_pend_d;
            err_q        <= err_d;
        end
    end

    // pc is frozen while draining, so it is also the outstanding request address
    assign imem_rd      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem_addr    = pc_q;
    assign if_id_instr  = ifid_q.instr;
    assign if_id_pc_inc = ifid_q.pc_inc;
    assign if_id_valid  = ifid_valid_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  pc_src;
    logic        flush;
    logic [15:0] br_target, jmp_target, jr_target;
    logic        stall, halt_dec;
    logic        imem_rd;
    logic [15:0] imem_addr, imem_data;
    logic        imem_done;
    logic [15:0] if_id_instr, if_id_pc_inc;
    logic        if_id_valid, err;

    logic        done_req;
    int          errors = 0;
    int          checks = 0;

    // Reference model: the fetch stream described as a pc plus a few mode flags
    logic [15:0] m_pc, m_redir, m_hold_instr, m_hold_inc, m_instr, m_inc;
    logic        m_valid, m_err, m_halted, m_draining, m_holding, m_halt_wait;

    always #5 clk = ~clk;

    fetch_pc_ctrl #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .flush(flush),
        .br_target(br_target), .jmp_target(jmp_target), .jr_target(jr_target),
        .stall(stall), .halt_dec(halt_dec), .imem_rd(imem_rd), .imem_addr(imem_addr),
        .imem_data(imem_data), .imem_done(imem_done), .if_id_instr(if_id_instr),
        .if_id_pc_inc(if_id_pc_inc), .if_id_valid(if_id_valid), .err(err)
    );

    // Instruction memory contents: word at address a
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA001 + {1'b0, a[15:1]};
    endfunction

    task automatic drive(input logic [2:0] s, input logic f, input logic st,
                         input logic h, input logic d);
        pc_src = s; flush = f; stall = st; halt_dec = h; done_req = d;
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        imem_done = 1'b0;
        m_pc = 16'h0000; m_redir = 16'h0000; m_hold_instr = 16'h0800; m_hold_inc = 16'h0000;
        m_instr = 16'h0800; m_inc = 16'h0000; m_valid = 1'b0; m_err = 1'b0;
        m_halted = 1'b0; m_draining = 1'b0; m_holding = 1'b0; m_halt_wait = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        assert_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: present memory response, advance DUT and model, return at negedge
    task automatic tick();
        logic        redir, bad, dn, m_rd;
        logic [15:0] tgt, tgt_al, word, pc2;
        logic [15:0] n_pc, n_redir, n_hi, n_hinc, n_instr, n_inc;
        logic        n_valid, n_halted, n_draining, n_holding, n_halt_wait;
        imem_done = done_req & imem_rd;
        imem_data = mem_word(imem_addr);
        m_rd  = !(m_halted || m_holding);
        dn    = done_req && m_rd;
        word  = mem_word(m_pc);
        pc2   = m_pc + 16'd2;
        redir = flush && (pc_src == 3'b011 || pc_src == 3'b100 || pc_src == 3'b010);
        bad   = !redir && !(pc_src == 3'b001 && !flush);
        case (pc_src)
            3'b011:  tgt = br_target;
            3'b100:  tgt = jmp_target;
            default: tgt = jr_target;
        endcase
        tgt_al = tgt & 16'hFFFE;
        n_pc = m_pc; n_redir = m_redir; n_hi = m_hold_instr; n_hinc = m_hold_inc;
        n_instr = m_instr; n_inc = m_inc; n_valid = m_valid; n_halted = m_halted;
        n_draining = m_draining; n_holding = m_holding; n_halt_wait = m_halt_wait;
        if (m_halted) begin
            // nothing moves until reset
        end else if (m_draining) begin
            if (redir) n_redir = tgt_al;
            if (dn) begin
                n_pc = redir ? tgt_al : m_redir;
                n_draining = 1'b0;
            end
        end else if (m_holding) begin
            if (redir || halt_dec) begin
                n_holding = 1'b0; n_instr = 16'h0800; n_inc = 16'h0000; n_valid = 1'b0;
                if (redir) n_pc = tgt_al; else n_halted = 1'b1;
            end else if (!stall) begin
                n_holding = 1'b0; n_instr = m_hold_instr; n_inc = m_hold_inc; n_valid = 1'b1;
            end
        end else if (redir) begin
            n_instr = 16'h0800; n_inc = 16'h0000; n_valid = 1'b0; n_halt_wait = 1'b0;
            if (dn) n_pc = tgt_al;
            else begin n_draining = 1'b1; n_redir = tgt_al; end
        end else if (halt_dec || m_halt_wait) begin
            n_instr = 16'h0800; n_inc = 16'h0000; n_valid = 1'b0;
            if (dn) begin n_halted = 1'b1; n_halt_wait = 1'b0; end
            else n_halt_wait = 1'b1;
        end else if (dn) begin
            n_pc = pc2;
            if (stall) begin n_holding = 1'b1; n_hi = word; n_hinc = pc2; end
            else begin n_instr = word; n_inc = pc2; n_valid = 1'b1; end
        end else if (!stall) begin
            n_instr = 16'h0800; n_inc = 16'h0000; n_valid = 1'b0;
        end
        @(posedge clk);
        m_pc = n_pc; m_redir = n_redir; m_hold_instr = n_hi; m_hold_inc = n_hinc;
        m_instr = n_instr; m_inc = n_inc; m_valid = n_valid; m_halted = n_halted;
        m_draining = n_draining; m_holding = n_holding; m_halt_wait = n_halt_wait;
        m_err = m_err | bad | (redir & tgt[0]);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        assert_reset();
        #2;
        checks++;
        if (if_id_instr !== 16'h0800 || if_id_valid !== 1'b0 || if_id_pc_inc !== 16'h0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ifid: got instr=%h inc=%h valid=%b err=%b want 0800 0000 0 0",
                     if_id_instr, if_id_pc_inc, if_id_valid, err);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_fetch: got rd=%b addr=%h want 1 0000", imem_rd, imem_addr);
        end
    endtask

    task automatic test_seq_fetch();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_rd !== 1'b1 || imem_addr !== 16'(2 * i)) begin
                errors++;
                $display("FAIL seq_addr: got rd=%b addr=%h want 1 %h", imem_rd, imem_addr, 16'(2 * i));
            end
            drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            checks++;
            if (if_id_instr !== 16'hA001 + 16'(i) || if_id_pc_inc !== 16'(2 * i + 2) || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_ifid: got %h/%h/%b want %h/%h/1", if_id_instr, if_id_pc_inc,
                         if_id_valid, 16'hA001 + 16'(i), 16'(2 * i + 2));
            end
        end
    endtask

    task automatic test_stall_hold();
        // pc is 0008, IF/ID holds A004/0008
        for (int i = 0; i < 3; i++) begin
            drive(3'b001, 1'b0, 1'b1, 1'b0, 1'b1);
            tick();
            checks++;
            if (imem_rd !== 1'b0 || if_id_instr !== 16'hA004 || if_id_pc_inc !== 16'h0008 || if_id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_frozen: got rd=%b ifid=%h/%h/%b want 0 A004/0008/1",
                         imem_rd, if_id_instr, if_id_pc_inc, if_id_valid);
            end
        end
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (if_id_instr !== 16'hA005 || if_id_pc_inc !== 16'h000A || if_id_valid !== 1'b1 ||
            imem_rd !== 1'b1 || imem_addr !== 16'h000A) begin
            errors++;
            $display("FAIL stall_release: got ifid=%h/%h/%b rd=%b addr=%h want A005/000A/1 1 000A",
                     if_id_instr, if_id_pc_inc, if_id_valid, imem_rd, imem_addr);
        end
    endtask

    task automatic test_redirect_drain();
        jmp_target = 16'h0010;
        drive(3'b100, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (imem_addr !== 16'h0010 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0800) begin
            errors++;
            $display("FAIL jump_same_cycle: got addr=%h ifid=%h/%b want 0010 0800/0", imem_addr, if_id_instr, if_id_valid);
        end
        br_target = 16'h0040;
        drive(3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (imem_rd !== 1'b1 || imem_addr !== 16'h0010 || if_id_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_hold: got rd=%b addr=%h valid=%b want 1 0010 0", imem_rd, imem_addr, if_id_valid);
            end
            drive(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0040 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0800) begin
            errors++;
            $display("FAIL drain_done: got rd=%b addr=%h ifid=%h/%b want 1 0040 0800/0",
                     imem_rd, imem_addr, if_id_instr, if_id_valid);
        end
        tick();
        checks++;
        if (if_id_instr !== 16'hA021 || if_id_pc_inc !== 16'h0042 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_target_fetch: got %h/%h/%b want A021/0042/1", if_id_instr, if_id_pc_inc, if_id_valid);
        end
    endtask

    task automatic test_wrap();
        jmp_target = 16'hFFFE;
        drive(3'b100, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (imem_addr !== 16'h0000 || if_id_pc_inc !== 16'h0000 || if_id_instr !== 16'h2000 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got addr=%h ifid=%h/%h/%b want 0000 2000/0000/1",
                     imem_addr, if_id_instr, if_id_pc_inc, if_id_valid);
        end
    endtask

    task automatic test_halt_vs_redirect();
        jmp_target = 16'h0100;
        drive(3'b100, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0100 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_vs_redirect: got rd=%b addr=%h valid=%b want 1 0100 0", imem_rd, imem_addr, if_id_valid);
        end
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (if_id_instr !== 16'hA081 || if_id_pc_inc !== 16'h0102 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL after_redirect: got %h/%h/%b want A081/0102/1", if_id_instr, if_id_pc_inc, if_id_valid);
        end
    endtask

    task automatic test_halt();
        drive(3'b001, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0102 || if_id_instr !== 16'h0800 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_pending: got rd=%b addr=%h ifid=%h/%b want 1 0102 0800/0",
                     imem_rd, imem_addr, if_id_instr, if_id_valid);
        end
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        jmp_target = 16'h0200;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_rd !== 1'b0 || if_id_instr !== 16'h0800 || if_id_valid !== 1'b0) begin
                errors++;
                $display("FAIL halted: got rd=%b ifid=%h/%b want 0 0800/0", imem_rd, if_id_instr, if_id_valid);
            end
            drive(3'b100, 1'b1, i[0], 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic test_rst_mid_drain();
        do_reset();
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        br_target = 16'h0030;
        drive(3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL drain_entry: got rd=%b addr=%h want 1 0004", imem_rd, imem_addr);
        end
        #2;
        assert_reset();
        #1;
        checks++;
        if (imem_rd !== 1'b1 || imem_addr !== 16'h0000 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drain: got rd=%b addr=%h valid=%b want 1 0000 0", imem_rd, imem_addr, if_id_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(3'b001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (if_id_instr !== 16'hA001 || if_id_pc_inc !== 16'h0002 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_fetch: got %h/%h/%b want A001/0002/1", if_id_instr, if_id_pc_inc, if_id_valid);
        end
    endtask

    task automatic test_misaligned();
        do_reset();
        jr_target = 16'h1235;
        drive(3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (imem_addr !== 16'h1234 || err !== 1'b1) begin
            errors++;
            $display("FAIL misaligned: got addr=%h err=%b want 1234 1", imem_addr, err);
        end
        drive(3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++;
        if (imem_addr !== 16'h1236 || if_id_instr !== 16'hA91B || if_id_valid !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_seq: got addr=%h ifid=%h/%b err=%b want 1236 A91B/1 1",
                     imem_addr, if_id_instr, if_id_valid, err);
        end
    endtask

    task automatic test_random();
        logic [2:0] codes [4];
        int r;
        codes[0] = 3'b011; codes[1] = 3'b100; codes[2] = 3'b010; codes[3] = 3'b111;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            br_target  = 16'($urandom) & ((c > 2000 && r[0]) ? 16'hFFFF : 16'hFFFE);
            jmp_target = 16'($urandom) & 16'hFFFE;
            jr_target  = 16'($urandom) & 16'hFFFE;
            if (r < 12)
                drive(codes[$urandom_range(0, 2)], 1'b1, ($urandom_range(0, 2) == 0),
                      1'b0, ($urandom_range(0, 1) == 0));
            else if (r < 14 && c > 2000)
                drive(codes[$urandom_range(0, 3)], 1'b0, 1'b0, 1'b0, 1'b1);
            else
                drive(3'b001, 1'b0, ($urandom_range(0, 2) == 0), 1'b0, ($urandom_range(0, 1) == 0));
            tick();
            checks++;
            if (imem_rd !== !(m_halted || m_holding) || imem_addr !== m_pc || if_id_instr !== m_instr ||
                if_id_pc_inc !== m_inc || if_id_valid !== m_valid || err !== m_err) begin
                errors++;
                $display("FAIL random_cycle %0d: got rd=%b addr=%h ifid=%h/%h/%b err=%b want rd=%b addr=%h ifid=%h/%h/%b err=%b",
                         c, imem_rd, imem_addr, if_id_instr, if_id_pc_inc, if_id_valid, err,
                         !(m_halted || m_holding), m_pc, m_instr, m_inc, m_valid, m_err);
            end
        end
    endtask

    initial begin
        br_target = 16'h0000; jmp_target = 16'h0000; jr_target = 16'h0000;
        imem_data = 16'h0000; imem_done = 1'b0;
        assert_reset();
        test_reset();
        test_seq_fetch();
        test_stall_hold();
        test_redirect_drain();
        test_wrap();
        test_halt_vs_redirect();
        test_halt();
        test_rst_mid_drain();
        test_misaligned();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Fetch-stage PC sequencer and IF/ID register owner.
- Consumes pc_src/flush from the decode-stage branch resolver plus the three candidate targets, drives the stalling instruction memory, and presents instr/pc_inc to decode.
- Handles memory wait states, hazard stalls (one-entry skid buffer), redirects during outstanding fetches, and halt.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, bubble instruction written into IF/ID on flush, reset, or halt.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- pc_src  in  3  001 seq (PC+2), 011 branch target, 100 jump target, 010 register target
- flush  in  1  redirect valid; qualifies pc_src != 001
- br_target  in  16  branch target (decode-computed)
- jmp_target  in  16  PC-relative jump target
- jr_target  in  16  register jump target
- stall  in  1  hazard-unit stall of IF/ID
- halt_dec  in  1  HALT decoded in the IF/ID instruction
- imem_rd  out  1  fetch request
- imem_addr  out  16  fetch address (= pc or drain address)
- imem_data  in  16  instruction, valid when imem_done
- imem_done  in  1  fetch complete this cycle
- if_id_instr  out  16  IF/ID instruction
- if_id_pc_inc  out  16  IF/ID PC+2 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- err  out  1  sticky illegal-control flag

Behaviour:
- Reset (async): pc=RESET_PC, state=FETCH, if_id_instr=NOP_INSTR, if_id_pc_inc=0, if_id_valid=0, hold empty, redirect reg=0, err=0. imem_rd=1 in the first cycle after reset release.
- States: FETCH, DRAIN, HOLD, HALT.
  - FETCH: imem_rd=1, imem_addr=pc.
  - DRAIN: imem_rd=1, imem_addr=the pending address latched when the request was issued; held stable.
  - HOLD and HALT: imem_rd=0.
- Memory rule: imem_rd and imem_addr stay stable until imem_done.
- Redirect (flush=1 and pc_src in {011,100,010}):
  - Target is selected by pc_src.
  - IF/ID loads NOP_INSTR with valid=0.
  - Hold buffer is discarded.
- Priority each cycle: rst > redirect > halt_dec > stall > normal fetch.
- FETCH, normal case:
  - imem_done & !stall: IF/ID <= {imem_data, pc+2, valid=1}; pc <= pc+2. Latency: instruction in IF/ID the cycle after done.
  - imem_done & stall: data and pc+2 go to the hold buffer; pc <= pc+2; IF/ID unchanged; go HOLD.
  - !imem_done: stay in FETCH; a stall alone holds pc and IF/ID.
- FETCH with redirect:
  - imem_done same cycle: discard data, pc <= target, stay in FETCH.
  - !imem_done: latch target in the redirect reg, go DRAIN.
- DRAIN:
  - On imem_done: discard data, pc <= redirect reg, go FETCH.
  - A further redirect while in DRAIN overwrites the redirect reg (latest wins).
  - IF/ID holds NOP, valid=0, throughout.
- HOLD:
  - When stall=0: IF/ID <= hold buffer, go FETCH.
  - Redirect while in HOLD: drop the hold buffer, pc <= target, go FETCH.
- Halt (halt_dec=1, no redirect):
  - pc frozen; IF/ID <= NOP, valid=0; go HALT.
  - If a request is outstanding, HALT is entered only after its imem_done; the data is discarded.
  - HALT is left only via rst.
- Arithmetic: pc+2 is mod 2^16 (16'hFFFE -> 16'h0000).
- Target alignment: target bit0 is forced to 0; if the selected target had bit0=1, err is set.
- Illegal control: pc_src not in {001,011,100,010}, or pc_src=001 with flush=1, or pc_src!=001 with flush=0. Each sets err and is treated as sequential (no redirect).
- stall during HALT or DRAIN is ignored.

Decomposition:
- Shared package fetch_pkg:
  - pc_src encodings: PCSRC_SEQ=3'b001, PCSRC_BR=3'b011, PCSRC_JMP=3'b100, PCSRC_JR=3'b010.
  - State enum: FETCH, DRAIN, HOLD, HALT.
  - NOP_INSTR constant.
- One natural sub-module: next_pc_sel. Combinational target mux plus alignment and illegal-encoding check; outputs next_pc and err_pulse.
- Registers, FSM and skid buffer stay in fetch_pc_ctrl.

Test Plan:
- Reset, imem_done=1 every cycle, data 16'hA001, 16'hA002 -> imem_addr 0,2,4...; IF/ID=A001/pc_inc 2, then A002/pc_inc 4; valid=1 from cycle 2.
- Stall=1 for 3 cycles with a done arriving -> IF/ID frozen, imem_rd=0 in HOLD; stall drop -> IF/ID loads buffered instr; next imem_addr = buffered pc+2.
- imem_done low 4 cycles at pc=16'h0010, flush+pc_src=011, br_target=16'h0040 in cycle 1 -> imem_addr stays 0010 until done; data discarded; next imem_addr=0040; if_id_valid=0 meanwhile.
- flush+pc_src=010, jr_target=16'h1235 -> pc=16'h1234, err=1 sticky; pc_src=3'b111 -> sequential fetch, err stays 1.
- pc=16'hFFFE, done -> next imem_addr=16'h0000, if_id_pc_inc=16'h0000.
- halt_dec=1 -> IF/ID=16'h0800, valid=0, imem_rd=0 forever. halt_dec and flush (jmp_target=16'h0100) in the same cycle -> redirect wins, fetch 0100. rst mid-DRAIN -> pc=0, state FETCH.
